// File: rtl/great_operand_streamer.sv
// great_operand_streamer
// Holds two wide operands and streams them out as aligned limb pairs,
// least-significant limb first, with valid/final framing. Optionally runs
// an MSB-first magnitude compare first so the streamed A is never below
// the streamed B; the resulting exchange is reported on swapped_out.
// BITS_IN_NUM must be an exact multiple of REGISTER_SIZE.

module great_operand_streamer #(
  parameter int REGISTER_SIZE  = 32,
  parameter int BITS_IN_NUM    = 2048,
  parameter bit ORDER_OPERANDS = 1'b1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [BITS_IN_NUM-1:0]   a_in,
  input  logic [BITS_IN_NUM-1:0]   b_in,
  input  logic                     start_in,
  input  logic                     pause_in,
  output logic                     ready_out,
  output logic [REGISTER_SIZE-1:0] a_out,
  output logic [REGISTER_SIZE-1:0] b_out,
  output logic                     valid_out,
  output logic                     final_out,
  output logic                     swapped_out
);

  localparam int NUM_LIMBS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int IDX_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  // cnt counts limbs already emitted, so it must be able to hold NUM_LIMBS
  localparam int CNT_W     = $clog2(NUM_LIMBS + 1);

  localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NUM_LIMBS - 1);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(NUM_LIMBS);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    STREAM
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         cmp_idx_q, cmp_idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     swap_q, swap_d;

  logic [BITS_IN_NUM-1:0]   a_reg, b_reg;
  logic                     capture;

  // Emission request for the output registers this cycle
  logic                     emit;
  logic                     emit_swap;
  logic [IDX_W-1:0]         emit_idx;
  logic [BITS_IN_NUM-1:0]   src_a, src_b;

  logic [REGISTER_SIZE-1:0] cmp_a, cmp_b;
  logic [REGISTER_SIZE-1:0] a_d, b_d;
  logic                     valid_d, final_d, ready_d;

  function automatic logic [REGISTER_SIZE-1:0] limb_of(
    input logic [BITS_IN_NUM-1:0] v,
    input logic [IDX_W-1:0]       k
  );
    return v[int'(k) * REGISTER_SIZE +: REGISTER_SIZE];
  endfunction

  assign cmp_a = limb_of(a_reg, cmp_idx_q);
  assign cmp_b = limb_of(b_reg, cmp_idx_q);

  // Next-state and next-output decode; the first limb is emitted on the
  // same edge that enters STREAM so valid follows start/compare directly.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    cmp_idx_d = cmp_idx_q;
    cnt_d     = cnt_q;
    swap_d    = swap_q;
    capture   = 1'b0;
    emit      = 1'b0;
    emit_swap = swap_q;
    emit_idx  = '0;
    src_a     = a_reg;
    src_b     = b_reg;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          capture = 1'b1;
          swap_d  = 1'b0;
          if (ORDER_OPERANDS) begin
            state_d   = COMPARE;
            cmp_idx_d = TOP_IDX;
          end else begin
            // Registers are loading this edge, so take limb 0 from the inputs
            state_d   = STREAM;
            emit      = 1'b1;
            emit_swap = 1'b0;
            src_a     = a_in;
            src_b     = b_in;
            cnt_d     = CNT_W'(1);
          end
        end
      end

      COMPARE: begin
        if (cmp_a > cmp_b || (cmp_a == cmp_b && cmp_idx_q == '0)) begin
          state_d   = STREAM;
          emit      = 1'b1;
          emit_swap = 1'b0;
          cnt_d     = CNT_W'(1);
          cmp_idx_d = '0;
        end else if (cmp_a < cmp_b) begin
          state_d   = STREAM;
          swap_d    = 1'b1;
          emit      = 1'b1;
          emit_swap = 1'b1;
          cnt_d     = CNT_W'(1);
          cmp_idx_d = '0;
        end else begin
          cmp_idx_d = cmp_idx_q - IDX_W'(1);
        end
      end

      STREAM: begin
        if (cnt_q == DONE_CNT) begin
          // Last limb is on the outputs now; drop back so ready rises next
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!pause_in) begin
          emit     = 1'b1;
          emit_idx = cnt_q[IDX_W-1:0];
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    valid_d = emit;
    final_d = emit && (emit_idx == TOP_IDX);
    a_d     = '0;
    b_d     = '0;
    if (emit) begin
      // Swapping only exchanges which stored register feeds which output
      a_d = emit_swap ? limb_of(src_b, emit_idx) : limb_of(src_a, emit_idx);
      b_d = emit_swap ? limb_of(src_a, emit_idx) : limb_of(src_b, emit_idx);
    end
    ready_d = (state_d == IDLE);
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge clk_in) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_in) begin
      state_q   <= IDLE;
      cmp_idx_q <= '0;
      cnt_q     <= '0;
      swap_q    <= 1'b0;
      ready_out <= 1'b1;
      valid_out <= 1'b0;
      final_out <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
    end else begin
      state_q   <= state_d;
      cmp_idx_q <= cmp_idx_d;
      cnt_q     <= cnt_d;
      swap_q    <= swap_d;
      ready_out <= ready_d;
      valid_out <= valid_d;
      final_out <= final_d;
      a_out     <= a_d;
      b_out     <= b_d;
    end
  end

  assign swapped_out = swap_q;

  // Operand storage, loaded only on an accepted start
  always_ff @(posedge clk_in) begin
    // NOTE: wide data storage is deliberately left out of reset; its
    // contents are never observed before the next capture.
    if (capture) begin
      a_reg <= a_in;
      b_reg <= b_in;
    end
  end

endmodule

// File: tb/tb_great_operand_streamer.sv
// Testbench for great_operand_streamer: three instances (128-bit unordered,
// 128-bit ordered, 2048-bit ordered) driven from a per-cycle vector table
// plus hand-written reset-abort and full-width equal-operand sequences.

module tb_great_operand_streamer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 128-bit instances: index 0 = unordered, 1 = ordered
  logic [127:0] a_n[2];
  logic [127:0] b_n[2];
  logic         start_i[2];
  logic         pause_i[2];
  logic         ready_o[2];
  logic [31:0]  a_o[2];
  logic [31:0]  b_o[2];
  logic         valid_o[2];
  logic         final_o[2];
  logic         swapped_o[2];

  // 2048-bit ordered instance
  logic [2047:0] a2, b2;
  logic          start2, pause2;
  logic          ready2, valid2, final2, swapped2;
  logic [31:0]   a2o, b2o;

  great_operand_streamer #(
    .REGISTER_SIZE(32), .BITS_IN_NUM(128), .ORDER_OPERANDS(1'b0)
  ) dut0 (
    .clk_in(clk), .rst_in(rst), .a_in(a_n[0]), .b_in(b_n[0]),
    .start_in(start_i[0]), .pause_in(pause_i[0]), .ready_out(ready_o[0]),
    .a_out(a_o[0]), .b_out(b_o[0]), .valid_out(valid_o[0]),
    .final_out(final_o[0]), .swapped_out(swapped_o[0])
  );

  great_operand_streamer #(
    .REGISTER_SIZE(32), .BITS_IN_NUM(128), .ORDER_OPERANDS(1'b1)
  ) dut1 (
    .clk_in(clk), .rst_in(rst), .a_in(a_n[1]), .b_in(b_n[1]),
    .start_in(start_i[1]), .pause_in(pause_i[1]), .ready_out(ready_o[1]),
    .a_out(a_o[1]), .b_out(b_o[1]), .valid_out(valid_o[1]),
    .final_out(final_o[1]), .swapped_out(swapped_o[1])
  );

  great_operand_streamer #(
    .REGISTER_SIZE(32), .BITS_IN_NUM(2048), .ORDER_OPERANDS(1'b1)
  ) dut2 (
    .clk_in(clk), .rst_in(rst), .a_in(a2), .b_in(b2),
    .start_in(start2), .pause_in(pause2), .ready_out(ready2),
    .a_out(a2o), .b_out(b2o), .valid_out(valid2),
    .final_out(final2), .swapped_out(swapped2)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Inputs applied during one cycle; expectations observed in the next
  typedef struct {
    int           dut;
    logic         start;
    logic         pause;
    logic [127:0] opa;
    logic [127:0] opb;
    logic         valid;
    logic         fin;
    logic         ready;
    logic         swp;
    logic [31:0]  a;
    logic [31:0]  b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(int dut, logic start, logic pause,
                               logic [127:0] opa, logic [127:0] opb,
                               logic valid, logic fin, logic ready, logic swp,
                               logic [31:0] a, logic [31:0] b);
    vec_t r;
    r.dut = dut; r.start = start; r.pause = pause; r.opa = opa; r.opb = opb;
    r.valid = valid; r.fin = fin; r.ready = ready; r.swp = swp; r.a = a; r.b = b;
    return r;
  endfunction

  localparam logic [127:0] A0 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] B0 = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [127:0] XX = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE;
  localparam logic [127:0] A1 = 128'h5;
  localparam logic [127:0] B1 = 128'h1_00000000;
  localparam logic [127:0] C9 = 128'h00000007_00000000_00000000_00000009;
  localparam logic [127:0] C8 = 128'h00000007_00000000_00000000_00000008;

  initial begin
    int d;
    int ncmp, good, nfin;
    logic fin_last, sw_first;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_n[i] = '0; b_n[i] = '0; start_i[i] = 1'b0; pause_i[i] = 1'b0;
    end
    a2 = '0; b2 = '0; start2 = 1'b0; pause2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset / idle state on all instances
    for (int i = 0; i < 2; i++) begin
      check($sformatf("idle%0d ready", i),   32'(ready_o[i]),   32'd1);
      check($sformatf("idle%0d valid", i),   32'(valid_o[i]),   32'd0);
      check($sformatf("idle%0d final", i),   32'(final_o[i]),   32'd0);
      check($sformatf("idle%0d swapped", i), 32'(swapped_o[i]), 32'd0);
      check($sformatf("idle%0d a", i),       a_o[i],            32'd0);
      check($sformatf("idle%0d b", i),       b_o[i],            32'd0);
    end
    check("idle2 ready", 32'(ready2), 32'd1);
    check("idle2 valid", 32'(valid2), 32'd0);
    check("idle2 a",     a2o,         32'd0);

    // Unordered: plain stream, back-to-back restart, pause gap, ignored start
    vecs.push_back(mkv(0, 1, 0, A0, B0, 1, 0, 0, 0, 32'h1, 32'hA));
    vecs.push_back(mkv(0, 0, 0, A0, B0, 1, 0, 0, 0, 32'h2, 32'hB));
    vecs.push_back(mkv(0, 0, 0, A0, B0, 1, 0, 0, 0, 32'h3, 32'hC));
    vecs.push_back(mkv(0, 0, 0, A0, B0, 1, 1, 0, 0, 32'h4, 32'hD));
    vecs.push_back(mkv(0, 0, 0, A0, B0, 0, 0, 1, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(0, 1, 0, A0, B0, 1, 0, 0, 0, 32'h1, 32'hA));
    vecs.push_back(mkv(0, 0, 0, A0, B0, 1, 0, 0, 0, 32'h2, 32'hB));
    vecs.push_back(mkv(0, 1, 1, XX, XX, 0, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(0, 0, 1, A0, B0, 0, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(0, 0, 0, A0, B0, 1, 0, 0, 0, 32'h3, 32'hC));
    vecs.push_back(mkv(0, 0, 0, A0, B0, 1, 1, 0, 0, 32'h4, 32'hD));
    vecs.push_back(mkv(0, 0, 0, A0, B0, 0, 0, 1, 0, 32'h0, 32'h0));
    // Ordered: A<B at limb 1 -> 3 compare cycles, swap; pause ignored in COMPARE
    vecs.push_back(mkv(1, 1, 0, A1, B1, 0, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(1, 0, 1, A1, B1, 0, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(1, 0, 1, A1, B1, 0, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(1, 0, 1, A1, B1, 1, 0, 0, 1, 32'h0, 32'h5));
    vecs.push_back(mkv(1, 0, 0, A1, B1, 1, 0, 0, 1, 32'h1, 32'h0));
    vecs.push_back(mkv(1, 0, 0, A1, B1, 1, 0, 0, 1, 32'h0, 32'h0));
    vecs.push_back(mkv(1, 0, 0, A1, B1, 1, 1, 0, 1, 32'h0, 32'h0));
    vecs.push_back(mkv(1, 0, 0, A1, B1, 0, 0, 1, 1, 32'h0, 32'h0));
    // Ordered: differ only at limb 0 (A>B) -> 4 compare cycles, swap cleared
    vecs.push_back(mkv(1, 1, 0, C9, C8, 0, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(1, 0, 0, C9, C8, 0, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(1, 0, 0, C9, C8, 0, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(1, 0, 0, C9, C8, 0, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(1, 0, 0, C9, C8, 1, 0, 0, 0, 32'h9, 32'h8));
    vecs.push_back(mkv(1, 0, 0, C9, C8, 1, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(1, 0, 0, C9, C8, 1, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mkv(1, 0, 0, C9, C8, 1, 1, 0, 0, 32'h7, 32'h7));
    vecs.push_back(mkv(1, 0, 0, C9, C8, 0, 0, 1, 0, 32'h0, 32'h0));

    for (int k = 0; k < vecs.size(); k++) begin
      for (int i = 0; i < 2; i++) begin
        start_i[i] = 1'b0; pause_i[i] = 1'b0;
      end
      d = vecs[k].dut;
      start_i[d] = vecs[k].start;
      pause_i[d] = vecs[k].pause;
      a_n[d]     = vecs[k].opa;
      b_n[d]     = vecs[k].opb;
      @(negedge clk);
      check($sformatf("v%0d valid", k),   32'(valid_o[d]),   32'(vecs[k].valid));
      check($sformatf("v%0d final", k),   32'(final_o[d]),   32'(vecs[k].fin));
      check($sformatf("v%0d ready", k),   32'(ready_o[d]),   32'(vecs[k].ready));
      check($sformatf("v%0d swapped", k), 32'(swapped_o[d]), 32'(vecs[k].swp));
      check($sformatf("v%0d a", k),       a_o[d],            vecs[k].a);
      check($sformatf("v%0d b", k),       b_o[d],            vecs[k].b);
    end
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; pause_i[i] = 1'b0;
    end

    // Reset during limb 2 aborts; a following start completes normally
    a_n[0] = A0; b_n[0] = B0;
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst limb2 a", a_o[0], 32'h3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst ready",   32'(ready_o[0]),   32'd1);
    check("rst valid",   32'(valid_o[0]),   32'd0);
    check("rst final",   32'(final_o[0]),   32'd0);
    check("rst swapped", 32'(swapped_o[0]), 32'd0);
    check("rst a",       a_o[0],            32'd0);
    check("rst b",       b_o[0],            32'd0);
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("post-rst limb%0d valid", j), 32'(valid_o[0]), 32'd1);
      check($sformatf("post-rst limb%0d a", j),     a_o[0],           32'(j + 1));
      check($sformatf("post-rst limb%0d b", j),     b_o[0],           32'(j + 10));
      check($sformatf("post-rst limb%0d final", j), 32'(final_o[0]),  32'(j == 3));
      @(negedge clk);
    end
    check("post-rst ready", 32'(ready_o[0]), 32'd1);

    // 2048-bit equal operands: 64 compare cycles, no swap, 64 all-ones limbs
    a2 = '1; b2 = '1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    pause2 = 1'b1;  // ignored during COMPARE
    ncmp = 0;
    while (!valid2 && ncmp < 200) begin
      ncmp++;
      @(negedge clk);
    end
    pause2 = 1'b0;
    check("wide compare cycles", 32'(ncmp), 32'd64);
    good = 0; nfin = 0; fin_last = 1'b0; sw_first = swapped2;
    for (int j = 0; j < 64; j++) begin
      if (valid2 && a2o == 32'hFFFFFFFF && b2o == 32'hFFFFFFFF) good++;
      if (final2) begin
        nfin++;
        if (j == 63) fin_last = 1'b1;
      end
      @(negedge clk);
    end
    check("wide good limbs",  32'(good),     32'd64);
    check("wide final count", 32'(nfin),     32'd1);
    check("wide final last",  32'(fin_last), 32'd1);
    check("wide swapped",     32'(sw_first), 32'd0);
    check("wide end valid",   32'(valid2),   32'd0);
    check("wide end ready",   32'(ready2),   32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
